// File: rtl/header_word_scheduler_pkg.sv
// header_word_scheduler_pkg: shared constants and state encoding for the header word scheduler
`ifndef IOQ_SRC_PORT_POS
`define IOQ_SRC_PORT_POS 16
`endif
package header_word_scheduler_pkg;
    localparam logic [7:0] IOQ_CTRL = 8'hFF;
    typedef enum logic [1:0] {ST_IDLE, ST_MODHDR, ST_DATA, ST_DRAIN} state_t;
    localparam logic [2:0] WI_MAC_DST   = 3'd0;
    localparam logic [2:0] WI_ETHERTYPE = 3'd1;
    localparam logic [2:0] WI_TTL       = 3'd2;
    localparam logic [2:0] WI_IP_SRC    = 3'd3;
    localparam logic [2:0] WI_IP_DST_LO = 3'd4;
endpackage

// File: rtl/header_word_scheduler.sv
// header_word_scheduler: issues per-field word strobes to the header parser and gates packet starts
module header_word_scheduler
    import header_word_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter logic [CTRL_WIDTH-1:0] IOQ_CTRL = CTRL_WIDTH'(header_word_scheduler_pkg::IOQ_CTRL),
    parameter int CNT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    input  logic                  header_parser_in_rdy,
    output logic                  word_IOQ,
    output logic                  word_MAC_DST,
    output logic                  word_MAC_SRC_HI,
    output logic                  word_MAC_SRC_LO,
    output logic                  word_ETHERTYPE,
    output logic                  word_IP_TTL,
    output logic                  word_IP_SRC,
    output logic                  word_IP_DST_HI,
    output logic                  word_IP_DST_LO,
    output logic                  word_LAST_USEFUL,
    output logic                  missing_ioq,
    output logic                  runt_pkt,
    output logic [CNT_WIDTH-1:0]  num_pkts,
    output logic [CNT_WIDTH-1:0]  num_runts
);
    state_t state, state_nxt;
    logic [2:0] wi, wi_nxt, didx;
    logic acc, is_ioq, is_data, data_word, eop, pkt_done;

    // back-pressure only gates a packet start; reset forces the idle view combinationally
    assign in_rdy = (!reset && state != ST_IDLE) || header_parser_in_rdy;
    assign acc = in_wr && in_rdy && !reset;
    assign is_ioq = in_ctrl == IOQ_CTRL;
    assign is_data = in_ctrl == '0;

    always_comb begin
        state_nxt = state;
        wi_nxt = wi;
        didx = wi;
        data_word = 1'b0;
        eop = 1'b0;
        pkt_done = 1'b0;
        word_IOQ = 1'b0;
        word_MAC_DST = 1'b0;
        word_MAC_SRC_HI = 1'b0;
        word_MAC_SRC_LO = 1'b0;
        word_ETHERTYPE = 1'b0;
        word_IP_TTL = 1'b0;
        word_IP_SRC = 1'b0;
        word_IP_DST_HI = 1'b0;
        word_IP_DST_LO = 1'b0;
        word_LAST_USEFUL = 1'b0;
        missing_ioq = 1'b0;
        runt_pkt = 1'b0;
        if (acc) begin
            case (state)
                ST_IDLE, ST_MODHDR: begin
                    word_IOQ = is_ioq;
                    missing_ioq = state == ST_IDLE && is_data;
                    data_word = is_data;
                    didx = WI_MAC_DST;
                    state_nxt = ST_MODHDR;
                end
                ST_DATA: begin
                    data_word = 1'b1;
                    eop = !is_data;
                end
                default: begin
                    state_nxt = is_data ? ST_DRAIN : ST_IDLE;
                    pkt_done = !is_data;
                end
            endcase
        end
        // an early EOP still closes the packet with LAST_USEFUL so parser FIFOs stay aligned
        if (data_word) begin
            word_MAC_DST = didx == WI_MAC_DST;
            word_MAC_SRC_HI = didx == WI_MAC_DST;
            word_MAC_SRC_LO = didx == WI_ETHERTYPE;
            word_ETHERTYPE = didx == WI_ETHERTYPE;
            word_IP_TTL = didx == WI_TTL;
            word_IP_SRC = didx == WI_IP_SRC;
            word_IP_DST_HI = didx == WI_IP_SRC;
            word_IP_DST_LO = didx == WI_IP_DST_LO;
            word_LAST_USEFUL = word_IP_DST_LO || eop;
            runt_pkt = eop && !word_IP_DST_LO;
            pkt_done = eop;
            state_nxt = eop ? ST_IDLE : (word_IP_DST_LO ? ST_DRAIN : ST_DATA);
            wi_nxt = (eop || word_IP_DST_LO) ? 3'd0 : didx + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            wi <= 3'd0;
            num_pkts <= '0;
            num_runts <= '0;
        end else begin
            state <= state_nxt;
            wi <= wi_nxt;
            if (pkt_done) num_pkts <= num_pkts + CNT_WIDTH'(1);
            if (runt_pkt) num_runts <= num_runts + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_header_word_scheduler.sv
// tb_header_word_scheduler: randomized and directed checks against a packet-position reference model
module tb_header_word_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_wr = 1'b0;
    logic header_parser_in_rdy = 1'b0;
    logic [7:0] in_ctrl = 8'h00;
    logic in_rdy;
    logic word_IOQ, word_MAC_DST, word_MAC_SRC_HI, word_MAC_SRC_LO, word_ETHERTYPE;
    logic word_IP_TTL, word_IP_SRC, word_IP_DST_HI, word_IP_DST_LO, word_LAST_USEFUL;
    logic missing_ioq, runt_pkt;
    logic [31:0] num_pkts, num_runts;
    logic [11:0] obs;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int exp_pkts = 0;
    int exp_runts = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    logic [7:0] pkt[$];

    header_word_scheduler dut (
        .clk(clk), .reset(reset), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
        .header_parser_in_rdy(header_parser_in_rdy),
        .word_IOQ(word_IOQ), .word_MAC_DST(word_MAC_DST), .word_MAC_SRC_HI(word_MAC_SRC_HI),
        .word_MAC_SRC_LO(word_MAC_SRC_LO), .word_ETHERTYPE(word_ETHERTYPE), .word_IP_TTL(word_IP_TTL),
        .word_IP_SRC(word_IP_SRC), .word_IP_DST_HI(word_IP_DST_HI), .word_IP_DST_LO(word_IP_DST_LO),
        .word_LAST_USEFUL(word_LAST_USEFUL), .missing_ioq(missing_ioq), .runt_pkt(runt_pkt),
        .num_pkts(num_pkts), .num_runts(num_runts)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign obs = {word_IOQ, word_MAC_DST, word_MAC_SRC_HI, word_MAC_SRC_LO, word_ETHERTYPE, word_IP_TTL,
                  word_IP_SRC, word_IP_DST_HI, word_IP_DST_LO, word_LAST_USEFUL, missing_ioq, runt_pkt};

    function automatic int first_data();
        for (int i = 0; i < pkt.size(); i++) if (pkt[i] == 8'h00) return i;
        return pkt.size();
    endfunction

    // expected strobes from the word's position relative to the first data word and the packet end
    function automatic logic [11:0] exp_vec(input int i);
        int f = first_data();
        int last = pkt.size() - 1;
        int k = i - f;
        logic [11:0] v = '0;
        if (i < f) v[11] = pkt[i] == 8'hFF;
        else begin
            v[10] = k == 0;
            v[9]  = k == 0;
            v[8]  = k == 1;
            v[7]  = k == 1;
            v[6]  = k == 2;
            v[5]  = k == 3;
            v[4]  = k == 3;
            v[3]  = k == 4;
            v[2]  = k == 4 || (i == last && k < 4);
            v[1]  = f == 0 && i == 0;
            v[0]  = i == last && k < 4;
        end
        return v;
    endfunction

    task automatic make_pkt(input int nmod, input int ndata);
        pkt.delete();
        for (int j = 0; j < nmod; j++)
            pkt.push_back((j == 0 || $urandom_range(3) == 0) ? 8'hFF : 8'($urandom_range(254, 1)));
        for (int j = 0; j < ndata - 1; j++) pkt.push_back(8'h00);
        pkt.push_back(8'($urandom_range(255, 1)));
    endtask

    task automatic send_pkt(input int gap_pct, input bit rnd_bp, input bit drop_mid);
        logic [11:0] e = '0;
        int n = pkt.size();
        for (int i = 0; i < n; i++) begin
            if (int'($urandom_range(99)) < gap_pct) begin
                @(posedge clk); #1;
                in_wr = 1'b0;
                in_ctrl = 8'($urandom);
                if (rnd_bp && i > 0) header_parser_in_rdy = 1'($urandom_range(1));
                @(negedge clk);
                checks++;
                if (obs !== 12'h000) begin errors++; $display("FAIL gap_strobes word %0d: got %h want 000", i, obs); end
                if (i > 0) begin
                    checks++;
                    if (in_rdy !== 1'b1) begin errors++; $display("FAIL gap_in_rdy word %0d: got %b want 1", i, in_rdy); end
                end
            end
            @(posedge clk); #1;
            in_wr = 1'b1;
            in_ctrl = pkt[i];
            if (i == 0) begin
                int waits = 0;
                if (rnd_bp) header_parser_in_rdy = 1'($urandom_range(1));
                while (!header_parser_in_rdy) begin
                    @(negedge clk);
                    checks++;
                    if (in_rdy !== 1'b0 || obs !== 12'h000) begin
                        errors++; $display("FAIL bp_hold: got in_rdy=%b strobes=%h want 0/000", in_rdy, obs);
                    end
                    @(posedge clk); #1;
                    waits++;
                    header_parser_in_rdy = rnd_bp ? ($urandom_range(3) == 0 || waits >= 20) : (waits >= 5);
                end
            end else if (rnd_bp || drop_mid) header_parser_in_rdy = drop_mid ? 1'b0 : 1'($urandom_range(1));
            @(negedge clk);
            e = exp_vec(i);
            checks++;
            if (in_rdy !== 1'b1) begin errors++; $display("FAIL in_rdy word %0d: got %b want 1", i, in_rdy); end
            checks++;
            if (obs !== e) begin errors++; $display("FAIL strobes word %0d ctrl %h: got %h want %h", i, pkt[i], obs, e); end
            if (i == 0) begin
                first_cyc = cyc;
                checks++;
                if (num_pkts !== 32'(exp_pkts) || num_runts !== 32'(exp_runts)) begin
                    errors++; $display("FAIL counters_at_start: got %0d/%0d want %0d/%0d", num_pkts, num_runts, exp_pkts, exp_runts);
                end
            end
            if (i == n - 1) last_cyc = cyc;
        end
        exp_pkts++;
        if (e[0]) exp_runts++;
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk); #1;
        in_wr = 1'b0;
        in_ctrl = 8'h00;
        header_parser_in_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (num_pkts !== 32'(exp_pkts) || num_runts !== 32'(exp_runts)) begin
            errors++; $display("FAIL %s_counters: got %0d/%0d want %0d/%0d", tag, num_pkts, num_runts, exp_pkts, exp_runts);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; header_parser_in_rdy = 1'b0; in_wr = 1'b1; in_ctrl = 8'hFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_rdy !== 1'b0 || obs !== 12'h000) begin errors++; $display("FAIL reset_outputs: got %b/%h want 0/000", in_rdy, obs); end
        checks++;
        if (num_pkts !== 32'd0 || num_runts !== 32'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", num_pkts, num_runts); end
        header_parser_in_rdy = 1'b1;
        #1;
        checks++;
        if (in_rdy !== 1'b1 || obs !== 12'h000) begin errors++; $display("FAIL reset_rdy_follow: got %b/%h want 1/000", in_rdy, obs); end
        @(posedge clk); #1;
        reset = 1'b0; in_wr = 1'b0;
    endtask

    task automatic test_ip_back_to_back();
        int lc;
        header_parser_in_rdy = 1'b1;
        pkt = '{8'hFF, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
        send_pkt(0, 1'b0, 1'b0);
        lc = last_cyc;
        send_pkt(0, 1'b0, 1'b0);
        checks++;
        if (first_cyc - lc !== 1) begin errors++; $display("FAIL back_to_back_gap: got %0d want 1", first_cyc - lc); end
        idle_check("ip_b2b");
    endtask

    task automatic test_runt();
        pkt = '{8'hFF, 8'h00, 8'h01};
        send_pkt(0, 1'b0, 1'b0);
        idle_check("runt");
    endtask

    task automatic test_missing_ioq();
        pkt = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
        send_pkt(0, 1'b0, 1'b0);
        idle_check("missing_ioq");
    endtask

    task automatic test_backpressure();
        header_parser_in_rdy = 1'b0;
        pkt = '{8'hFF, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40};
        send_pkt(0, 1'b0, 1'b1);
        idle_check("backpressure");
    endtask

    task automatic test_gaps();
        pkt = '{8'hFF, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
        send_pkt(100, 1'b0, 1'b0);
        idle_check("gaps");
    endtask

    task automatic test_random();
        for (int p = 0; p < 40; p++) begin
            make_pkt($urandom_range(3), $urandom_range(9, 2));
            send_pkt(25, 1'b1, 1'b0);
        end
        idle_check("random");
    endtask

    task automatic test_reset_mid();
        logic [11:0] e;
        header_parser_in_rdy = 1'b1;
        pkt = '{8'hFF, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_wr = 1'b1; in_ctrl = pkt[i];
            @(negedge clk);
            e = exp_vec(i);
            checks++;
            if (obs !== e) begin errors++; $display("FAIL pre_reset word %0d: got %h want %h", i, obs, e); end
        end
        @(posedge clk); #1;
        reset = 1'b1; header_parser_in_rdy = 1'b0; in_ctrl = 8'h00;
        @(negedge clk);
        checks++;
        if (in_rdy !== 1'b0 || obs !== 12'h000) begin errors++; $display("FAIL mid_reset_outputs: got %b/%h want 0/000", in_rdy, obs); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (num_pkts !== 32'd0 || num_runts !== 32'd0 || in_rdy !== 1'b0) begin
            errors++; $display("FAIL mid_reset_state: got %0d/%0d rdy %b want 0/0 rdy 0", num_pkts, num_runts, in_rdy);
        end
        @(posedge clk); #1;
        reset = 1'b0; in_wr = 1'b0; header_parser_in_rdy = 1'b1;
        exp_pkts = 0; exp_runts = 0;
        pkt = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
        send_pkt(0, 1'b0, 1'b0);
        idle_check("after_reset");
    endtask

    initial begin
        test_reset();
        test_ip_back_to_back();
        test_runt();
        test_missing_ioq();
        test_backpressure();
        test_gaps();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
